// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a credit-limited FIFO and redirect flush.
// Optional same-cycle response bypass to decode: define FETCH_BYPASS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instru,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instru;
  } fetch_ent_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  fetch_ent_t    fifo_mem [FIFO_DEPTH];
  fetch_ent_t    head;

  logic [CW:0]   credit_used;
  logic [31:0]   redir_tgt;
  logic          accept;
  logic          rv_cnt;
  logic          drop;
  logic          keep;
  logic          fifo_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [CW-1:0] out_nxt;
  logic [CW-1:0] out_less_rv;

  assign redir_tgt   = {redirect_pc[31:2], 2'b00};
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign imem_req    = rst_n && !redirect &&
                       (credit_used < {1'b0, DEPTH_C});
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;

  // Responses with no matching request (e.g. after reset) are not counted.
  assign rv_cnt      = imem_rvalid && (outstanding != '0);
  assign drop        = imem_rvalid && (discard != '0);
  assign keep        = imem_rvalid && (discard == '0) && !redirect;
  assign fifo_empty  = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass      = rst_n && keep && fifo_empty;
`else
  assign bypass      = 1'b0;
`endif

  assign head        = fifo_mem[rd_ptr];
  assign if_valid    = rst_n && !redirect && (!fifo_empty || bypass);
  assign pop         = if_valid && id_ready && !fifo_empty;
  assign push        = keep && !(bypass && id_ready);

  always_comb begin
    if_instru = 32'h0;
    if_pc     = 32'h0;
    if (!fifo_empty) begin
      if_instru = head.instru;
      if_pc     = head.pc;
    end else if (bypass) begin
      if_instru = imem_rdata;
      if_pc     = resp_pc;
    end
  end

  assign out_less_rv = outstanding - CW'(rv_cnt);
  assign out_nxt     = outstanding + CW'(accept) - CW'(rv_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      // Every response still in flight belongs to the old stream.
      fetch_pc    <= redir_tgt;
      resp_pc     <= redir_tgt;
      outstanding <= out_less_rv;
      discard     <= out_less_rv;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= out_nxt;
      if (drop) begin
        discard <= discard - 1'b1;
      end
      if (keep) begin
        resp_pc <= resp_pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{pc: resp_pc, instru: imem_rdata};
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    push |-> (count < DEPTH_C)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against an epoch-tagged stream model.
// Directed phases cover streaming, stall, redirects and address wrap.
module tb_fetch_unit;

  localparam int D = 4;
  localparam logic [31:0] DX = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_instru;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instru   (if_instru),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          cur_ep = 0;
  int          buffered = 0;
  int          n_cons = 0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_dec = 32'h0;

  int          p_rdy = 100;
  int          p_idr = 100;
  int          p_rv = 100;
  int          lat_max = 1;
  bit          hold = 1'b0;
  bit          do_redir = 1'b0;
  logic [31:0] redir_tgt = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic model_reset();
    mq.delete();
    cur_ep    = 0;
    buffered  = 0;
    exp_fetch = 32'h0;
    exp_dec   = 32'h0;
  endtask

  // Called at a negedge; returns at the negedge after release.
  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_ready  = 1'b1;
    id_ready    = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instru", if_instru, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    model_reset();
    do_redir = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait next negedge.
  task automatic step();
    bit rv;
    bit kept;
    bit exp_req;
    bit exp_val;
    redirect    = do_redir;
    redirect_pc = redir_tgt;
    imem_ready  = roll(p_rdy);
    id_ready    = roll(p_idr);
    rv = !hold && (mq.size() > 0) && (mq[0].due <= cyc) && roll(p_rv);
    imem_rvalid = rv;
    imem_rdata  = rv ? (mq[0].addr ^ DX) : $urandom;
    #1;
    kept    = rv && (mq[0].ep == cur_ep) && !do_redir;
    exp_req = !do_redir && ((mq.size() + buffered) < D);
`ifdef FETCH_BYPASS_EN
    exp_val = !do_redir && ((buffered > 0) || kept);
`else
    exp_val = !do_redir && (buffered > 0);
`endif
    chk("req", 32'(imem_req), 32'(exp_req));
    chk("valid", 32'(if_valid), 32'(exp_val));
    if (if_valid) begin
      chk("pc", if_pc, exp_dec);
      chk("instru", if_instru, exp_dec ^ DX);
    end
    if (if_valid && id_ready) n_cons++;
    if (rv) begin
      void'(mq.pop_front());
      if (kept) buffered++;
    end
    if (exp_val && id_ready) begin
      buffered--;
      exp_dec += 32'd4;
    end
    if (imem_req && imem_ready) begin
      chk("addr", imem_addr, exp_fetch);
      mq.push_back('{imem_addr, cur_ep,
                     cyc + int'($urandom_range(lat_max, 1))});
      exp_fetch += 32'd4;
    end
    if (do_redir) begin
      cur_ep++;
      buffered  = 0;
      exp_fetch = {redir_tgt[31:2], 2'b00};
      exp_dec   = {redir_tgt[31:2], 2'b00};
    end
    do_redir = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redir(input logic [31:0] tgt);
    do_redir  = 1'b1;
    redir_tgt = tgt;
    step();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Streaming with single-cycle memory and no stall.
    n_cons = 0;
    run(10);
`ifdef FETCH_BYPASS_EN
    chk("thru", 32'(n_cons), 32'd9);
`else
    chk("thru", 32'(n_cons), 32'd8);
`endif

    // Decode stall fills the buffer, then drains in order.
    do_reset();
    p_idr = 0;
    run(10);
    chk("stall_req", 32'(imem_req), 32'h0);
    p_idr = 100;
    run(8);

    // Redirect with three requests outstanding.
    do_reset();
    hold = 1'b1;
    run(3);
    redir(32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    hold = 1'b0;
    run(12);

    // Second redirect while discards are still pending.
    do_reset();
    hold = 1'b1;
    run(3);
    redir(32'h0000_0103);
    run(1);
    redir(32'h0000_0200);
    chk("redir2_addr", imem_addr, 32'h0000_0200);
    hold = 1'b0;
    run(12);

    // Address wrap at the top of the address space.
    do_reset();
    redir(32'hFFFF_FFF8);
    chk("wrap0", imem_addr, 32'hFFFF_FFF8);
    run(1);
    chk("wrap1", imem_addr, 32'hFFFF_FFFC);
    run(1);
    chk("wrap2", imem_addr, 32'h0000_0000);
    run(6);

    // Random traffic: variable latency, backpressure, redirects, resets.
    p_rdy = 70;
    p_idr = 70;
    p_rv = 70;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (roll(1) && ($urandom_range(3, 0) == 0)) begin
        do_reset();
      end else if (roll(3)) begin
        if ($urandom_range(3, 0) == 0)
          redir(32'hFFFF_FFF0 | ($urandom & 32'hF));
        else
          redir($urandom & 32'h0000_FFFF);
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >=2: instruction buffer entries and maximum in-flight request credit.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_ready  input  1  memory accepts request this cycle when imem_req=1.
REQ-008 imem_rvalid  input  1  read data valid; responses return in request order, at most one per cycle.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 if_valid  output  1  if_instru/if_pc hold a valid instruction for decode.
REQ-011 if_instru  output  32  instruction to decode.
REQ-012 if_pc  output  32  address of if_instru.
REQ-013 id_ready  input  1  decode consumes the head instruction when if_valid=1.
REQ-014 redirect  input  1  branch/jump redirect; flushes the fetch path.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).

Function
REQ-016 fetch_pc register drives imem_addr; request accepted when imem_req && imem_ready; fetch_pc += 4 on acceptance; 32-bit wrap from 32'hFFFF_FFFC to 0.
REQ-017 outstanding counter: +1 on acceptance, -1 on imem_rvalid; both in one cycle leaves it unchanged.
REQ-018 imem_req = !redirect && (outstanding + fifo_count < FIFO_DEPTH); the FIFO therefore never overflows and pushes when full are impossible by construction.
REQ-019 resp_pc register tags kept responses: entry written as {resp_pc, imem_rdata}; resp_pc += 4 per kept response.
REQ-020 FIFO: in-order; if_valid = !fifo_empty && !redirect; head entry drives if_instru/if_pc; pop when if_valid && id_ready; push and pop in the same cycle both take effect.
REQ-021 if_instru/if_pc hold their value while if_valid=1 and id_ready=0.
REQ-022 redirect (single-cycle): FIFO emptied; fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}; discard counter <= outstanding minus 1 if imem_rvalid that cycle; no request issued that cycle.
REQ-023 While discard counter > 0, each imem_rvalid decrements it and its data is dropped (no FIFO write, resp_pc unchanged).
REQ-024 Redirect while discard counter > 0: discard counter reloaded per REQ-022 (covers all still-outstanding responses).
REQ-025 New requests may issue from the cycle after redirect; credit per REQ-018 includes discarded outstanding responses.
REQ-026 Without decode stall and with single-cycle memory, sustained throughput is one instruction per cycle.

Reset
REQ-027 On rst_n low: fetch_pc=resp_pc=RESET_PC, outstanding=0, discard=0, FIFO empty.
REQ-028 During reset outputs: imem_req=0, if_valid=0, imem_addr=RESET_PC, if_instru=32'h0, if_pc=32'h0.
REQ-029 First request (imem_addr=RESET_PC) in the first cycle after rst_n deasserts.
REQ-030 Reset mid-operation discards all in-flight state; responses arriving after reset release are not tracked (memory is reset with the core).

Configuration
REQ-031 Macro FETCH_BYPASS_EN defined: when FIFO empty, discard=0, no redirect and imem_rvalid=1, if_valid=1 the same cycle with if_instru=imem_rdata, if_pc=resp_pc; entry written to FIFO only if id_ready=0.
REQ-032 FETCH_BYPASS_EN undefined: every kept response written to FIFO; if_valid rises the cycle after imem_rvalid (one-cycle added latency).

Verification
REQ-033 Reset release, imem_ready=1, 1-cycle memory returning addr as data, id_ready=1 -> if_pc sequence 0,4,8,C with if_instru equal; one per cycle after initial latency.
REQ-034 id_ready=0 for 10 cycles, FIFO_DEPTH=4 -> imem_req drops after outstanding+count=4; exactly 4 entries buffered; release yields PCs 0,4,8,C with none lost or duplicated.
REQ-035 Three requests outstanding (addresses 0,4,8), redirect with redirect_pc=32'h0000_0103 -> next request addr 32'h100; three stale responses dropped; first if_pc=32'h100.
REQ-036 Second redirect to 32'h200 two cycles after first while discards pending -> only 32'h200 stream reaches decode.
REQ-037 redirect_pc=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 With FETCH_BYPASS_EN, empty FIFO, rvalid with rdata=32'h0000_0013 -> if_valid=1 and if_instru=32'h13 in same cycle; without macro, one cycle later.
